mac_address_table: RTL and testbench



---
 rtl/mac_address_table.sv | 244 ++++++++++++++++++++++++
 tb/tb_mac_address_table.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_address_table.sv
// ---------------------------------------------------------------------------
// mac_address_table
// Two-way set-associative hashed MAC table: 256 rows x 2 ways.
// Every request does a destination lookup (result two cycles later) and a
// source learn (written in the result cycle). A background sweeper, started
// by i_age_tick, ages one row per cycle and expires stale entries.
//
// Ports
//   clk, rst              fabric clock, asynchronous active-high reset
//   i_lookup_en           request strobe, one cycle per request
//   i_lookup_src_vlan     VLAN of the frame (used for lookup and learn)
//   i_lookup_src_mac      source MAC to learn
//   i_lookup_src_port     ingress port to learn
//   i_lookup_dst_mac      destination MAC to look up
//   o_lookup_hit          destination found (valid two cycles after request)
//   o_lookup_dst_port     egress port, meaningful when o_lookup_hit=1
//   i_age_tick            pulse that starts one aging sweep
//   o_sweep_busy          high while a sweep is running
// ---------------------------------------------------------------------------
module mac_address_table #(
    parameter int NUM_PORTS = 28,
    parameter int AGE_MAX   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_lookup_en,
    input  logic [11:0] i_lookup_src_vlan,
    input  logic [47:0] i_lookup_src_mac,
    input  logic [4:0]  i_lookup_src_port,
    input  logic [47:0] i_lookup_dst_mac,
    output logic        o_lookup_hit,
    output logic [4:0]  o_lookup_dst_port,
    input  logic        i_age_tick,
    output logic        o_sweep_busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [5:0] LP_NUM_PORTS = 6'(NUM_PORTS);
    localparam logic [1:0] LP_AGE_EXP   = 2'(AGE_MAX - 1);

    // RAM entry: key {mac, vlan} in the upper bits, port in the low bits
    typedef struct packed {
        logic [47:0] mac;
        logic [11:0] vlan;
        logic [4:0]  port;
    } entry_t;

    function automatic logic [7:0] f_hash(input logic [47:0] mac, input logic [11:0] vlan);
        f_hash = mac[47:40] ^ mac[39:32] ^ mac[31:24] ^ mac[23:16] ^ mac[15:8] ^ mac[7:0]
               ^ vlan[7:0] ^ {4'b0, vlan[11:8]};
    endfunction

    // ---------------------------------------------------------------- stage 1
    logic [7:0]  w_dst_row;
    logic [7:0]  w_src_row;
    assign w_dst_row = f_hash(i_lookup_dst_mac, i_lookup_src_vlan);
    assign w_src_row = f_hash(i_lookup_src_mac, i_lookup_src_vlan);

    logic        r_s1_vld;
    logic [47:0] r_s1_dst_mac;
    logic [47:0] r_s1_src_mac;
    logic [11:0] r_s1_vlan;
    logic [4:0]  r_s1_src_port;
    logic [7:0]  r_s1_dst_row;
    logic [7:0]  r_s1_src_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld      <= 1'b0;
            r_s1_dst_mac  <= '0;
            r_s1_src_mac  <= '0;
            r_s1_vlan     <= '0;
            r_s1_src_port <= '0;
            r_s1_dst_row  <= '0;
            r_s1_src_row  <= '0;
        end else begin
            r_s1_vld <= i_lookup_en;
            if (i_lookup_en) begin
                r_s1_dst_mac  <= i_lookup_dst_mac;
                r_s1_src_mac  <= i_lookup_src_mac;
                r_s1_vlan     <= i_lookup_src_vlan;
                r_s1_src_port <= i_lookup_src_port;
                r_s1_dst_row  <= w_dst_row;
                r_s1_src_row  <= w_src_row;
            end
        end
    end

    // Stage-2 write port (learn), driven from stage-2 logic below
    logic        w_wr_en;
    logic        w_wr_way;
    logic [7:0]  w_wr_row;
    entry_t      w_wr_data;

    // Per-way payload RAM: port A reads the dst row, port B the src row.
    // A write landing on the same edge as a read is forwarded so the next
    // request sees the previous request's learn.
    entry_t [1:0]      w_rd_a;
    logic [1:0][59:0]  w_rd_b_key;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_way
            localparam logic LP_WAY = 1'(g);
            entry_t      r_mem [256];
            entry_t      r_rd_a;
            logic [59:0] r_rd_b_key;
            logic        w_wr_this;

            assign w_wr_this = w_wr_en && (w_wr_way == LP_WAY);

            always_ff @(posedge clk) begin
                if (w_wr_this)
                    r_mem[w_wr_row] <= w_wr_data;
                if (i_lookup_en) begin
                    r_rd_a     <= (w_wr_this && w_wr_row == w_dst_row) ? w_wr_data
                                                                       : r_mem[w_dst_row];
                    r_rd_b_key <= (w_wr_this && w_wr_row == w_src_row) ? w_wr_data[64:5]
                                                                       : r_mem[w_src_row][64:5];
                end
            end

            assign w_rd_a[g]     = r_rd_a;
            assign w_rd_b_key[g] = r_rd_b_key;
        end
    endgenerate

    // ------------------------------------------------------ valid/age flops
    logic [1:0]      r_valid [256];
    logic [1:0][1:0] r_age   [256];

    logic [0:0]  r_state;
    logic [7:0]  r_sweep_row;

    // ---------------------------------------------------------------- stage 2
    logic [1:0]      w_dv;
    logic [1:0]      w_sv;
    logic [1:0][1:0] w_sage;
    logic [1:0]      w_dmatch;
    logic [1:0]      w_smatch;

    assign w_dv   = r_valid[r_s1_dst_row];
    assign w_sv   = r_valid[r_s1_src_row];
    assign w_sage = r_age[r_s1_src_row];

    generate
        for (g = 0; g < 2; g++) begin : g_match
            assign w_dmatch[g] = w_dv[g] && (w_rd_a[g][64:5] == {r_s1_dst_mac, r_s1_vlan});
            assign w_smatch[g] = w_sv[g] && (w_rd_b_key[g] == {r_s1_src_mac, r_s1_vlan});
        end
    endgenerate

    logic       w_hit;
    logic [4:0] w_hit_port;
    // Group-addressed destinations are never forwarded from the table
    assign w_hit      = (|w_dmatch) && !r_s1_dst_mac[40];
    assign w_hit_port = w_dmatch[0] ? w_rd_a[0].port : w_rd_a[1].port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_lookup_hit      <= 1'b0;
            o_lookup_dst_port <= '0;
        end else if (r_s1_vld) begin
            o_lookup_hit      <= w_hit;
            o_lookup_dst_port <= w_hit ? w_hit_port : 5'd0;
        end
    end

    // Learn: refresh a matching way (station move), else fill a victim
    logic w_learn_ok;
    assign w_learn_ok = r_s1_vld && !r_s1_src_mac[40]
                     && ({1'b0, r_s1_src_port} < LP_NUM_PORTS)
                     && (r_s1_src_mac != 48'd0);

    always_comb begin
        w_wr_way = 1'b0;
        if (w_smatch[0])      w_wr_way = 1'b0;
        else if (w_smatch[1]) w_wr_way = 1'b1;
        else if (!w_sv[0])    w_wr_way = 1'b0;
        else if (!w_sv[1])    w_wr_way = 1'b1;
        else                  w_wr_way = (w_sage[1] > w_sage[0]);
    end

    assign w_wr_en   = w_learn_ok;
    assign w_wr_row  = r_s1_src_row;
    assign w_wr_data = '{mac: r_s1_src_mac, vlan: r_s1_vlan, port: r_s1_src_port};

    // ---------------------------------------------------------------- sweeper
    logic [1:0]      w_sw_valid;
    logic [1:0][1:0] w_sw_age;

    generate
        for (g = 0; g < 2; g++) begin : g_sweep
            logic w_alive;
            assign w_alive       = r_valid[r_sweep_row][g] && (r_age[r_sweep_row][g] != LP_AGE_EXP);
            assign w_sw_valid[g] = w_alive;
            assign w_sw_age[g]   = w_alive ? r_age[r_sweep_row][g] + 2'd1 : r_age[r_sweep_row][g];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sweep_row <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_age_tick) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_row <= '0;
                    end
                end
                default: begin
                    r_sweep_row <= r_sweep_row + 8'd1;
                    if (r_sweep_row == 8'hFF)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sweep_busy = (r_state == ST_SWEEP);

    // Sweep updates the whole row first; a learn to the same (row, way)
    // is assigned afterwards so it wins for that way only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '{default: '0};
            r_age   <= '{default: '0};
        end else begin
            if (r_state == ST_SWEEP) begin
                r_valid[r_sweep_row] <= w_sw_valid;
                r_age[r_sweep_row]   <= w_sw_age;
            end
            if (w_wr_en) begin
                r_valid[w_wr_row][w_wr_way] <= 1'b1;
                r_age[w_wr_row][w_wr_way]   <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_mac_address_table.sv
// ---------------------------------------------------------------------------
// tb_mac_address_table
// Table-driven back-to-back requests plus hand-written sequences for
// collisions, aging sweeps and reset in flight. Lookup results are checked
// through a scoreboard queue popped two cycles after each request.
// ---------------------------------------------------------------------------
module tb_mac_address_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_lookup_en;
    logic [11:0] i_lookup_src_vlan;
    logic [47:0] i_lookup_src_mac;
    logic [4:0]  i_lookup_src_port;
    logic [47:0] i_lookup_dst_mac;
    logic        o_lookup_hit;
    logic [4:0]  o_lookup_dst_port;
    logic        i_age_tick;
    logic        o_sweep_busy;

    mac_address_table #(.NUM_PORTS(28), .AGE_MAX(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_lookup_en       (i_lookup_en),
        .i_lookup_src_vlan (i_lookup_src_vlan),
        .i_lookup_src_mac  (i_lookup_src_mac),
        .i_lookup_src_port (i_lookup_src_port),
        .i_lookup_dst_mac  (i_lookup_dst_mac),
        .o_lookup_hit      (o_lookup_hit),
        .o_lookup_dst_port (o_lookup_dst_port),
        .i_age_tick        (i_age_tick),
        .o_sweep_busy      (o_sweep_busy)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] MAC_A  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] MAC_B  = 48'h00_00_00_00_BB_01;
    localparam logic [47:0] MAC_C  = 48'h00_00_00_00_00_C0;
    localparam logic [47:0] MAC_D  = 48'h00_00_00_00_00_D0;
    localparam logic [47:0] MAC_G  = 48'h00_00_00_00_00_E0;
    localparam logic [47:0] MAC_MC = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MAC_U  = 48'h00_00_00_00_00_77;
    // Three MACs sharing row 0x13 on vlan 1
    localparam logic [47:0] MAC_M1 = 48'h02_00_00_00_00_10;
    localparam logic [47:0] MAC_M2 = 48'h02_00_00_00_10_00;
    localparam logic [47:0] MAC_M3 = 48'h02_00_00_10_00_00;
    localparam logic [47:0] MAC_E  = 48'h00_00_00_00_00_E5;
    localparam logic [47:0] MAC_H  = 48'h00_00_00_00_00_48;
    localparam logic [47:0] MAC_F  = 48'h00_00_00_00_00_4F;

    typedef struct {
        string      nm;
        bit         chk;
        bit         hit;
        logic [4:0] port;
    } exp_t;

    typedef struct {
        string       nm;
        logic [11:0] vlan;
        logic [47:0] src;
        logic [4:0]  sport;
        logic [47:0] dst;
        bit          chk;
        bit          hit;
        logic [4:0]  port;
        int          idle;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [1:0] pipe;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Tracks which cycles carry a result
    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= 2'b00;
        else     pipe <= {pipe[0], i_lookup_en};
    end

    always @(negedge clk) begin
        if (pipe[1]) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: result appeared with no pending request");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk) begin
                    check({mon_e.nm, "_hit"}, 32'(o_lookup_hit), 32'(mon_e.hit));
                    if (mon_e.hit)
                        check({mon_e.nm, "_port"}, 32'(o_lookup_dst_port), 32'(mon_e.port));
                end
            end
        end
    end

    task automatic req(input string nm, input logic [11:0] vlan, input logic [47:0] src,
                       input logic [4:0] sport, input logic [47:0] dst,
                       input bit chk, input bit hit, input logic [4:0] port);
        exp_t e;
        @(negedge clk);
        i_lookup_en       = 1'b1;
        i_lookup_src_vlan = vlan;
        i_lookup_src_mac  = src;
        i_lookup_src_port = sport;
        i_lookup_dst_mac  = dst;
        e = '{nm, chk, hit, port};
        sb_q.push_back(e);
    endtask

    task automatic lk(input string nm, input logic [11:0] vlan, input logic [47:0] dst,
                      input bit hit, input logic [4:0] port);
        req(nm, vlan, 48'h0, 5'd0, dst, 1'b1, hit, port);
    endtask

    task automatic learn(input string nm, input logic [11:0] vlan, input logic [47:0] src,
                         input logic [4:0] sport);
        req(nm, vlan, src, sport, MAC_U, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_lookup_en = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // One full sweep; optionally pulses a second tick mid-sweep that must be ignored
    task automatic sweep(input string nm, input bit inject);
        int cnt = 0;
        @(negedge clk);
        i_age_tick = 1'b1;
        @(negedge clk);
        i_age_tick = 1'b0;
        check({nm, "_busy_rise"}, 32'(o_sweep_busy), 32'd1);
        while (o_sweep_busy && cnt < 1000) begin
            cnt++;
            i_age_tick = inject && (cnt == 100);
            @(negedge clk);
        end
        i_age_tick = 1'b0;
        check({nm, "_len"}, cnt, 32'd256);
    endtask

    task automatic add(input string nm, input logic [11:0] vlan, input logic [47:0] src,
                       input logic [4:0] sport, input logic [47:0] dst, input bit chk,
                       input bit hit, input logic [4:0] port, input int idl);
        vec_t v;
        v = '{nm, vlan, src, sport, dst, chk, hit, port, idl};
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        i_lookup_en       = 1'b0;
        i_lookup_src_vlan = '0;
        i_lookup_src_mac  = '0;
        i_lookup_src_port = '0;
        i_lookup_dst_mac  = '0;
        i_age_tick        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hit",  32'(o_lookup_hit),      32'd0);
        check("rst_port", 32'(o_lookup_dst_port), 32'd0);
        check("rst_busy", 32'(o_sweep_busy),      32'd0);
        rst = 1'b0;
        idle(2);

        //   name          vlan   src     sport  dst     chk hit port idle
        add("learnA_miss", 12'd1, MAC_A,  5'd3,  MAC_U,  1, 0, 0,  0);
        add("bypassA",     12'd1, 48'h0,  5'd0,  MAC_A,  1, 1, 3,  0);
        add("ownB",        12'd1, MAC_B,  5'd5,  MAC_B,  1, 0, 0,  0);
        add("bypassB",     12'd1, 48'h0,  5'd0,  MAC_B,  1, 1, 5,  0);
        add("vlan2A",      12'd2, 48'h0,  5'd0,  MAC_A,  1, 0, 0,  0);
        add("bcast",       12'd1, 48'h0,  5'd0,  MAC_BC, 1, 0, 0,  0);
        add("mc_src",      12'd1, MAC_MC, 5'd4,  MAC_U,  1, 0, 0,  0);
        add("badport",     12'd1, MAC_C,  5'd30, MAC_U,  1, 0, 0,  0);
        add("lookupC",     12'd1, 48'h0,  5'd0,  MAC_C,  1, 0, 0,  0);
        add("moveA",       12'd1, MAC_A,  5'd7,  MAC_A,  1, 1, 3,  0);
        add("movedA",      12'd1, 48'h0,  5'd0,  MAC_A,  1, 1, 7,  0);
        add("learnD",      12'd1, MAC_D,  5'd9,  MAC_U,  1, 0, 0,  4);
        add("gapD",        12'd1, 48'h0,  5'd0,  MAC_D,  1, 1, 9,  0);
        add("zero_src",    12'd1, 48'h0,  5'd2,  MAC_U,  1, 0, 0,  0);
        add("lookup0",     12'd1, 48'h0,  5'd0,  48'h0,  1, 0, 0,  0);
        add("port27",      12'd1, MAC_G,  5'd27, MAC_U,  1, 0, 0,  0);
        add("lookupG",     12'd1, 48'h0,  5'd0,  MAC_G,  1, 1, 27, 0);

        foreach (tbl[i]) begin
            req(tbl[i].nm, tbl[i].vlan, tbl[i].src, tbl[i].sport, tbl[i].dst,
                tbl[i].chk, tbl[i].hit, tbl[i].port);
            if (tbl[i].idle > 0) idle(tbl[i].idle);
        end
        idle(3);
        drain();

        // Collision: M1 ages to 2, M2 fills way 1, M3 must evict M1 (way 0)
        learn("M1", 12'd1, MAC_M1, 5'd1);
        idle(3);
        drain();
        sweep("sw1", 1'b1);
        sweep("sw2", 1'b0);
        learn("M2", 12'd1, MAC_M2, 5'd2);
        idle(2);
        learn("M3", 12'd1, MAC_M3, 5'd6);
        idle(2);
        lk("M1_evicted", 12'd1, MAC_M1, 1'b0, 5'd0);
        lk("M2_kept",    12'd1, MAC_M2, 1'b1, 5'd2);
        lk("M3_new",     12'd1, MAC_M3, 1'b1, 5'd6);
        idle(3);
        drain();

        // Aging: fresh E survives two sweeps, expires on the third
        learn("E", 12'd3, MAC_E, 5'd11);
        idle(3);
        drain();
        sweep("age1", 1'b0);
        lk("E_age1", 12'd3, MAC_E, 1'b1, 5'd11);
        lk("A_expired", 12'd1, MAC_A, 1'b0, 5'd0);
        idle(3);
        drain();
        sweep("age2", 1'b0);
        lk("E_age2", 12'd3, MAC_E, 1'b1, 5'd11);
        idle(3);
        drain();
        sweep("age3", 1'b0);
        lk("E_age3", 12'd3, MAC_E, 1'b0, 5'd0);
        idle(3);
        drain();

        // Reset in flight: output held at hit, sweep running, learn in stage 1
        learn("H", 12'd5, MAC_H, 5'd12);
        lk("H_hit", 12'd5, MAC_H, 1'b1, 5'd12);
        idle(3);
        drain();
        check("hold_hit", 32'(o_lookup_hit), 32'd1);
        @(negedge clk);
        i_age_tick = 1'b1;
        @(negedge clk);
        i_age_tick = 1'b0;
        check("pre_rst_busy", 32'(o_sweep_busy), 32'd1);
        learn("F", 12'd5, MAC_F, 5'd13);
        @(negedge clk);
        i_lookup_en = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_hit",  32'(o_lookup_hit),      32'd0);
        check("midrst_port", 32'(o_lookup_dst_port), 32'd0);
        check("midrst_busy", 32'(o_sweep_busy),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);
        lk("F_lost",    12'd5, MAC_F, 1'b0, 5'd0);
        lk("H_cleared", 12'd5, MAC_H, 1'b0, 5'd0);
        idle(3);
        drain();
        check("post_rst_busy", 32'(o_sweep_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
